// File: rtl/hex.sv
// hex: shows a 16-bit value as four hex digits on a TM1637 LED driver.
// Runs the write-data, address/data and display-control frames over the two-wire bus.
module hex #(
  parameter int         CLK_DIV    = 100,
  parameter logic [2:0] BRIGHTNESS = 3'd7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_latch,
  input  logic [15:0] data_in,
  output logic        busy,
  output logic        scl_en,
  output logic        scl_out,
  output logic        sda_en,
  output logic        sda_out,
  input  logic        sda_in
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [127:0] SEG = {8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
                                  8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F};
  typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP} state_t;
  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    q_q, q_d;
  logic [2:0]    bit_q, bit_d;
  logic [2:0]    byte_q, byte_d;
  logic [15:0]   data_q, data_d;
  logic          ack_unused_q, ack_d;
  logic          tick, frame_end;
  logic [3:0]    nib;
  logic [7:0]    byte_v;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      div_q        <= '0;
      q_q          <= '0;
      bit_q        <= '0;
      byte_q       <= '0;
      data_q       <= '0;
      ack_unused_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      q_q          <= q_d;
      bit_q        <= bit_d;
      byte_q       <= byte_d;
      data_q       <= data_d;
      ack_unused_q <= ack_d;
    end
  end
  // byte 0: write-data cmd, 1: address 0, 2..5: digit segments, 6: display control
  always_comb begin
    tick      = div_q == DW'(CLK_DIV - 1);
    nib       = byte_q == 3'd2 ? data_q[15:12] : byte_q == 3'd3 ? data_q[11:8] :
                byte_q == 3'd4 ? data_q[7:4] : data_q[3:0];
    byte_v    = byte_q == 3'd0 ? 8'h40 : byte_q == 3'd1 ? 8'hC0 :
                byte_q == 3'd6 ? {5'b10001, BRIGHTNESS} : SEG[{nib, 3'b000} +: 8];
    frame_end = byte_q == 3'd0 || byte_q == 3'd5 || byte_q == 3'd6;
    state_d   = state_q;
    q_d       = q_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    data_d    = data_q;
    ack_d     = ack_unused_q;
    div_d     = (state_q == IDLE || tick) ? '0 : div_q + DW'(1);
    if (state_q == IDLE) begin
      if (data_latch) begin
        data_d  = data_in;
        state_d = START;
        q_d     = 2'd0;
        bit_d   = 3'd0;
        byte_d  = 3'd0;
      end
    end else if (tick) begin
      q_d = q_q + 2'd1;
      if (state_q == ACK && q_q == 2'd2) ack_d = sda_in;
      if (q_q == 2'd3) begin
        case (state_q)
          START: begin
            state_d = BIT;
            bit_d   = 3'd0;
          end
          BIT: begin
            state_d = bit_q == 3'd7 ? ACK : BIT;
            bit_d   = bit_q + 3'd1;
          end
          ACK: begin
            state_d = frame_end ? STOP : BIT;
            byte_d  = byte_q + 3'd1;
            bit_d   = 3'd0;
          end
          STOP:    state_d = byte_q == 3'd7 ? IDLE : START;
          default: state_d = IDLE;
        endcase
      end
    end
  end
  always_comb begin
    busy    = state_q != IDLE;
    scl_en  = 1'b1;
    sda_en  = state_q != ACK;
    scl_out = state_q == START ? q_q != 2'd3 :
              (state_q == BIT || state_q == ACK) ? q_q[1] :
              state_q == STOP ? q_q != 2'd0 : 1'b1;
    sda_out = state_q == START ? q_q == 2'd0 :
              state_q == BIT ? byte_v[bit_q] :
              state_q == STOP ? q_q == 2'd3 : 1'b1;
  end
endmodule

// File: tb/tb_hex.sv
// tb_hex: decodes the TM1637 bus from pad levels and checks frames, ACK release and handshake.
module tb_hex;
  logic clk = 0, rst = 0, latch0 = 0, latch1 = 0, sda_drv = 0;
  logic [15:0] din = 0;
  logic busy0, scl_en0, scl_o0, sda_en0, sda_o0;
  logic busy1, scl_en1, scl_o1, sda_en1, sda_o1;
  logic busy, scl_en, scl_o, sda_en, sda_o, scl_p, sda_p;
  int sel = 0;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;

  hex #(.CLK_DIV(4), .BRIGHTNESS(3'd7)) dut0 (.clk(clk), .rst(rst), .data_latch(latch0),
    .data_in(din), .busy(busy0), .scl_en(scl_en0), .scl_out(scl_o0), .sda_en(sda_en0),
    .sda_out(sda_o0), .sda_in(sda_drv));
  hex #(.CLK_DIV(4), .BRIGHTNESS(3'd2)) dut1 (.clk(clk), .rst(rst), .data_latch(latch1),
    .data_in(din), .busy(busy1), .scl_en(scl_en1), .scl_out(scl_o1), .sda_en(sda_en1),
    .sda_out(sda_o1), .sda_in(sda_drv));

  assign busy   = sel != 0 ? busy1 : busy0;
  assign scl_en = sel != 0 ? scl_en1 : scl_en0;
  assign scl_o  = sel != 0 ? scl_o1 : scl_o0;
  assign sda_en = sel != 0 ? sda_en1 : sda_en0;
  assign sda_o  = sel != 0 ? sda_o1 : sda_o0;
  assign scl_p  = scl_en ? scl_o : 1'b1;
  assign sda_p  = sda_en ? sda_o : sda_drv;

  function automatic void chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // bus monitor: START = 'h100, STOP = 'h200, otherwise a received byte
  int ev_q[$];
  int scl_rises = 0, scl_chg = 0, en_falls = 0, en_err = 0, busy_falls = 0;
  logic ps = 1, pd = 1, pe = 1, pb = 0;
  int bn = 0;
  logic [7:0] sh = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (scl_p != ps) scl_chg++;
      if (ps && scl_p && pd && !sda_p) begin
        ev_q.push_back('h100);
        bn = 0;
      end else if (ps && scl_p && !pd && sda_p) begin
        ev_q.push_back('h200);
        bn = 0;
      end else if (!ps && scl_p) begin
        scl_rises++;
        if (bn < 8) begin
          sh[bn] = sda_p;
          bn++;
          if (!sda_en) en_err++;
        end else begin
          if (sda_en) en_err++;
          ev_q.push_back(int'(sh));
          bn = 0;
        end
      end
      if (pe && !sda_en) en_falls++;
      if (pb && !busy) busy_falls++;
      ps = scl_p; pd = sda_p; pe = sda_en; pb = busy;
    end
  end

  task automatic run_update(input int s, input logic [15:0] v, input logic [31:0] segs,
                            input logic [7:0] ctl, input logic ack, input int mid);
    int base, rise0, fall0, err0, bf0, n;
    int exp_e[13];
    sel = s;
    sda_drv = ack;
    @(posedge clk);
    base = ev_q.size(); rise0 = scl_rises; fall0 = en_falls; err0 = en_err; bf0 = busy_falls;
    @(negedge clk);
    chk("busy_before_latch", int'(busy), 0);
    din = v;
    latch0 = s == 0;
    latch1 = s != 0;
    @(negedge clk);
    latch0 = 0;
    latch1 = 0;
    chk("busy_next_cycle", int'(busy), 1);
    n = 0;
    while (busy && n < 1800) begin
      @(negedge clk);
      n++;
      latch0 = s == 0 && n == mid;
      latch1 = s != 0 && n == mid;
      if (n == mid) din = 16'h5555;
    end
    latch0 = 0;
    latch1 = 0;
    chk("busy_low_in_time", int'(busy), 0);
    repeat (20) @(negedge clk);
    chk("stays_idle", int'(busy), 0);
    exp_e = '{'h100, 'h40, 'h200, 'h100, 'hC0, int'(segs[31:24]), int'(segs[23:16]),
              int'(segs[15:8]), int'(segs[7:0]), 'h200, 'h100, int'(ctl), 'h200};
    chk("event_count", ev_q.size() - base, 13);
    for (int i = 0; i < 13; i++)
      chk($sformatf("event%0d_of_%04h", i, v), base + i < ev_q.size() ? ev_q[base + i] : -1, exp_e[i]);
    chk("ack_slot_releases", en_falls - fall0, 7);
    chk("sda_en_per_slot", en_err - err0, 0);
    chk("scl_rises", scl_rises - rise0, 66);
    chk("busy_falls", busy_falls - bf0, 1);
  endtask

  typedef struct {
    int s;
    logic [15:0] v;
    logic [31:0] segs;
    logic [7:0] ctl;
    logic ack;
    int mid;
  } vec_t;
  vec_t tab[7];
  logic [7:0] seg_tab[16];

  initial begin
    int base, n;
    logic [15:0] rv;
    int rs;
    seg_tab = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
    tab[0] = '{0, 16'hBEEF, 32'h7C797971, 8'h8F, 1'b0, 0};
    tab[1] = '{1, 16'h0123, 32'h3F065B4F, 8'h8A, 1'b0, 0};
    tab[2] = '{0, 16'hBEEF, 32'h7C797971, 8'h8F, 1'b0, 300};
    tab[3] = '{0, 16'hBEEF, 32'h7C797971, 8'h8F, 1'b1, 0};
    tab[4] = '{0, 16'h4567, 32'h666D7D07, 8'h8F, 1'b1, 0};
    tab[5] = '{1, 16'h89AB, 32'h7F6F777C, 8'h8A, 1'b0, 0};
    tab[6] = '{1, 16'hCDEF, 32'h395E7971, 8'h8A, 1'b1, 0};
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_scl_en", int'(scl_en), 1);
    chk("rst_scl_out", int'(scl_o), 1);
    chk("rst_sda_en", int'(sda_en), 1);
    chk("rst_sda_out", int'(sda_o), 1);
    rst = 1;
    n = scl_chg;
    repeat (100) @(negedge clk);
    chk("idle_scl_edges", scl_chg - n, 0);
    chk("idle_busy", int'(busy), 0);
    for (int i = 0; i < 7; i++)
      run_update(tab[i].s, tab[i].v, tab[i].segs, tab[i].ctl, tab[i].ack, tab[i].mid);
    // reset pulse in the middle of the address/data frame
    sel = 0;
    sda_drv = 0;
    @(posedge clk);
    base = ev_q.size();
    @(negedge clk);
    din = 16'h1234;
    latch0 = 1;
    @(negedge clk);
    latch0 = 0;
    n = 0;
    while (ev_q.size() - base < 6 && n < 1800) begin
      @(negedge clk);
      n++;
    end
    chk("reached_frame2", int'(n < 1800), 1);
    repeat (7) @(negedge clk);
    #2 rst = 0;
    #1;
    chk("abort_busy", int'(busy0), 0);
    chk("abort_scl_en", int'(scl_en0), 1);
    chk("abort_scl_out", int'(scl_o0), 1);
    chk("abort_sda_en", int'(sda_en0), 1);
    chk("abort_sda_out", int'(sda_o0), 1);
    @(negedge clk);
    rst = 1;
    repeat (3) @(negedge clk);
    run_update(0, 16'hA5C3, {seg_tab[4'hA], seg_tab[4'h5], seg_tab[4'hC], seg_tab[4'h3]}, 8'h8F, 1'b0, 0);
    for (int k = 0; k < 5; k++) begin
      rv = 16'($urandom);
      rs = int'($urandom_range(0, 1));
      run_update(rs, rv, {seg_tab[rv[15:12]], seg_tab[rv[11:8]], seg_tab[rv[7:4]], seg_tab[rv[3:0]]},
                 8'h88 | (rs != 0 ? 8'd2 : 8'd7), 1'($urandom_range(0, 1)), 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
